// File: rtl/dtmf_pkg.sv
// Shared key codes, controller states and key helpers for the DTMF passcode controller.
package dtmf_pkg;

    localparam logic [3:0] KEY_D    = 4'd0;
    localparam logic [3:0] KEY_0    = 4'd10;
    localparam logic [3:0] KEY_STAR = 4'd11;
    localparam logic [3:0] KEY_HASH = 4'd12;
    localparam logic [3:0] KEY_A    = 4'd13;
    localparam logic [3:0] KEY_B    = 4'd14;
    localparam logic [3:0] KEY_C    = 4'd15;

    typedef enum logic [1:0] {
        IDLE,
        ENTRY,
        LOCKOUT
    } state_t;

    // Everything except * and # is a passcode digit, including D, A, B and C.
    function automatic logic is_digit(input logic [3:0] key);
        return (key != KEY_STAR) && (key != KEY_HASH);
    endfunction

endpackage

// File: rtl/dtmf_debounce.sv
// Turns per-frame detector results into single press events: a digit must be stable
// for DEB_FRAMES frames, and a new press needs REL_FRAMES silent frames first.
module dtmf_debounce #(
    parameter int DEB_FRAMES = 2,
    parameter int REL_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_frame,
    input  logic       i_dtmf_valid,
    input  logic [3:0] i_dtmf_data,
    output logic       o_press,
    output logic [3:0] o_press_code
);
    localparam logic [3:0] DEB_CNT = 4'(DEB_FRAMES);
    localparam logic [3:0] REL_CNT = 4'(REL_FRAMES);

    logic [3:0] r_cand;
    logic [3:0] r_run;
    logic [3:0] r_rel;
    logic       r_armed;
    logic [3:0] w_run_next;
    logic [3:0] w_rel_next;

    // A zero run length means there is no candidate, so any digit starts a fresh run.
    always_comb begin
        w_run_next = 4'd1;
        if ((r_run != 4'd0) && (i_dtmf_data == r_cand))
            w_run_next = (r_run == 4'd15) ? r_run : r_run + 4'd1;
        w_rel_next = (r_rel == 4'd15) ? r_rel : r_rel + 4'd1;
    end

    assign o_press      = i_frame & i_dtmf_valid & ~r_armed & (w_run_next == DEB_CNT);
    assign o_press_code = i_dtmf_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cand  <= 4'd0;
            r_run   <= 4'd0;
            r_rel   <= 4'd0;
            r_armed <= 1'b0;
        end else if (i_frame) begin
            if (i_dtmf_valid) begin
                r_cand <= i_dtmf_data;
                r_run  <= w_run_next;
                r_rel  <= 4'd0;
                if (o_press)
                    r_armed <= 1'b1;
            end else begin
                r_rel <= w_rel_next;
                if (w_rel_next >= REL_CNT) begin
                    r_armed <= 1'b0;
                    r_run   <= 4'd0;
                    r_cand  <= 4'd0;
                end
            end
        end
    end

endmodule

// File: rtl/dtmf_code_ctrl.sv
// Passcode sequencer: collects debounced key presses, checks them against i_code on #,
// and enforces an inter-digit timeout plus a lockout after repeated failures.
module dtmf_code_ctrl
    import dtmf_pkg::*;
#(
    parameter int CODE_LEN       = 4,
    parameter int DEB_FRAMES     = 2,
    parameter int REL_FRAMES     = 2,
    parameter int TIMEOUT_FRAMES = 195,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_FRAMES = 1170
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_frame,
    input  logic                  i_dtmf_valid,
    input  logic [3:0]            i_dtmf_data,
    input  logic [4*CODE_LEN-1:0] i_code,
    input  logic                  i_enable,
    output logic                  o_key_event,
    output logic [3:0]            o_key_code,
    output logic                  o_unlock,
    output logic                  o_fail,
    output logic                  o_locked,
    output logic [3:0]            o_digit_count
);
    localparam int TW = $clog2(TIMEOUT_FRAMES + 1);
    localparam int LW = $clog2(LOCKOUT_FRAMES + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_FRAMES - 1);
    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_FRAMES - 1);
    localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAILS - 1);
    localparam logic [3:0]    CODE_CNT  = 4'(CODE_LEN);

    state_t                r_state, w_state_next;
    logic [4*CODE_LEN-1:0] r_buf, w_buf_next;
    logic [3:0]            r_count, w_count_next;
    logic [FW-1:0]         r_fails, w_fails_next;
    logic [TW-1:0]         r_tmo, w_tmo_next;
    logic [LW-1:0]         r_lock_cnt, w_lock_next;
    logic                  r_unlock, w_unlock_next;
    logic                  r_fail, w_fail_next;
    logic                  r_key_event;
    logic [3:0]            r_key_code;
    logic                  w_press;
    logic [3:0]            w_press_code;
    logic [CODE_LEN-1:0]   w_digit_ok;
    logic                  w_match;

    // Disabled frames are hidden from the debouncer so no key events appear while off.
    dtmf_debounce #(
        .DEB_FRAMES (DEB_FRAMES),
        .REL_FRAMES (REL_FRAMES)
    ) u_debounce (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_frame      (i_frame & i_enable),
        .i_dtmf_valid (i_dtmf_valid),
        .i_dtmf_data  (i_dtmf_data),
        .o_press      (w_press),
        .o_press_code (w_press_code)
    );

    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_cmp
            assign w_digit_ok[gi] = (r_buf[4*gi +: 4] == i_code[4*gi +: 4]);
        end
    endgenerate

    assign w_match = (r_count == CODE_CNT) && (&w_digit_ok);

    always_comb begin
        w_state_next  = r_state;
        w_buf_next    = r_buf;
        w_count_next  = r_count;
        w_fails_next  = r_fails;
        w_tmo_next    = r_tmo;
        w_lock_next   = r_lock_cnt;
        w_unlock_next = 1'b0;
        w_fail_next   = 1'b0;

        // Timers are evaluated before the key so an expiring timeout hands the key to IDLE.
        if (i_frame) begin
            case (r_state)
                ENTRY: begin
                    if (r_tmo == TMO_LAST) begin
                        w_state_next = IDLE;
                        w_buf_next   = '0;
                        w_count_next = 4'd0;
                        w_tmo_next   = '0;
                    end else begin
                        w_tmo_next = r_tmo + 1'b1;
                    end
                end
                LOCKOUT: begin
                    if (r_lock_cnt == LOCK_LAST) begin
                        w_state_next = IDLE;
                        w_fails_next = '0;
                    end else begin
                        w_lock_next = r_lock_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (r_key_event) begin
            w_tmo_next = '0;
            case (w_state_next)
                IDLE: begin
                    if (is_digit(r_key_code)) begin
                        w_state_next = ENTRY;
                        w_buf_next   = {{(4*CODE_LEN-4){1'b0}}, r_key_code};
                        w_count_next = 4'd1;
                    end
                end
                ENTRY: begin
                    if (r_key_code == KEY_STAR) begin
                        w_state_next = IDLE;
                        w_buf_next   = '0;
                        w_count_next = 4'd0;
                    end else if (r_key_code == KEY_HASH) begin
                        w_buf_next   = '0;
                        w_count_next = 4'd0;
                        if (w_match) begin
                            w_unlock_next = 1'b1;
                            w_fails_next  = '0;
                            w_state_next  = IDLE;
                        end else begin
                            w_fail_next  = 1'b1;
                            w_fails_next = r_fails + 1'b1;
                            w_lock_next  = '0;
                            w_state_next = (r_fails == FAIL_LAST) ? LOCKOUT : IDLE;
                        end
                    end else if (r_count != CODE_CNT) begin
                        for (int d = 0; d < CODE_LEN; d++)
                            if (r_count == 4'(d))
                                w_buf_next[4*d +: 4] = r_key_code;
                        w_count_next = r_count + 4'd1;
                    end
                end
                default: ;
            endcase
        end

        if (!i_enable) begin
            w_state_next  = IDLE;
            w_buf_next    = '0;
            w_count_next  = 4'd0;
            w_fails_next  = '0;
            w_tmo_next    = '0;
            w_lock_next   = '0;
            w_unlock_next = 1'b0;
            w_fail_next   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_buf       <= '0;
            r_count     <= 4'd0;
            r_fails     <= '0;
            r_tmo       <= '0;
            r_lock_cnt  <= '0;
            r_unlock    <= 1'b0;
            r_fail      <= 1'b0;
            r_key_event <= 1'b0;
            r_key_code  <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_buf       <= w_buf_next;
            r_count     <= w_count_next;
            r_fails     <= w_fails_next;
            r_tmo       <= w_tmo_next;
            r_lock_cnt  <= w_lock_next;
            r_unlock    <= w_unlock_next;
            r_fail      <= w_fail_next;
            r_key_event <= w_press;
            if (!i_enable)
                r_key_code <= 4'd0;
            else if (w_press)
                r_key_code <= w_press_code;
        end
    end

    assign o_key_event   = r_key_event;
    assign o_key_code    = r_key_code;
    assign o_unlock      = r_unlock;
    assign o_fail        = r_fail;
    assign o_locked      = (r_state == LOCKOUT);
    assign o_digit_count = r_count;

endmodule
